// File: rtl/jk_pkg.sv
// Shared JK flip-flop action encodings and the excitation helper used by the
// modulo counter and its per-bit cells.
package jk_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   typedef logic [1:0] jk_pair_t;

   // Toggle-form excitation: only bits that change are toggled, so the set and
   // reset encodings are never produced.
   function automatic jk_pair_t jk_excite(input logic cur, input logic nxt);
      return (cur ^ nxt) ? JK_TOGGLE : JK_HOLD;
   endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/status bundle of the JK modulo counter: the master drives the
// controls, the counter (slave) returns the count and the terminal count.
interface jk_mod_counter_if #(
   parameter int unsigned WIDTH = 4
) ();

   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;

   modport master (
      output en, up, load, load_val,
      input  count, tc
   );

   modport slave (
      input  en, up, load, load_val,
      output count, tc
   );

endinterface

// File: rtl/jk_cell.sv
// One-bit JK flip-flop with asynchronous active-low clear.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic i_j,
   input  logic i_k,
   output logic o_q
);

   logic r_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_q <= 1'b0;
      end else begin
         unique case ({i_j, i_k})
            JK_HOLD:   r_q <= r_q;
            JK_RESET:  r_q <= 1'b0;
            JK_SET:    r_q <= 1'b1;
            JK_TOGGLE: r_q <= ~r_q;
         endcase
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter whose state lives entirely in a bank of jk_cell
// flip-flops; this level only computes next state, excitation and tc.
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic        clk,
   input  logic        clr,
   jk_mod_counter_if.slave bus
);

   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   localparam logic [WIDTH:0]   L_MOD   = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH:0]   L_MOD_X = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] L_TOP   = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] w_count;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH:0]   w_cnt_x;
   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_dec;
   logic [WIDTH:0]   w_load_x;
   logic             w_tc;

   // One bit wider so the wrap compares see carry/borrow instead of aliasing.
   assign w_cnt_x  = {1'b0, w_count};
   assign w_load_x = {1'b0, bus.load_val};
   assign w_inc    = w_cnt_x + 1'b1;
   assign w_dec    = w_cnt_x - 1'b1;

   always_comb begin
      w_next = w_count;
      if (bus.load) begin
         w_next = (w_load_x < L_MOD) ? bus.load_val : L_TOP;
      end else if (bus.en) begin
         if (bus.up) begin
            w_next = (w_inc > L_MOD_X) ? '0 : w_inc[WIDTH-1:0];
         end else begin
            // Borrow out of zero, or an out-of-range state, lands on the top value.
            w_next = (w_dec[WIDTH] || (w_cnt_x >= L_MOD)) ? L_TOP : w_dec[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      w_tc = 1'b0;
      if (bus.en && !bus.load) begin
         w_tc = bus.up ? (w_count == L_TOP) : (w_count == '0);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign {w_j[i], w_k[i]} = jk_excite(w_count[i], w_next[i]);

      jk_cell u_cell (
         .clk (clk),
         .clr (clr),
         .i_j (w_j[i]),
         .i_k (w_k[i]),
         .o_q (w_count[i])
      );
   end

   assign bus.count = w_count;
   assign bus.tc    = w_tc;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: MODULUS=10 and MODULUS=16 instances
// driven from a directed vector table with hand-computed count, tc and J/K.
module tb_jk_mod_counter;

   logic clk = 1'b0;
   logic clr = 1'b0;

   jk_mod_counter_if #(.WIDTH(4)) bus10 ();
   jk_mod_counter_if #(.WIDTH(4)) bus16 ();

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
      .clk (clk),
      .clr (clr),
      .bus (bus10.slave)
   );

   jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
      .clk (clk),
      .clr (clr),
      .bus (bus16.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       sel;
      logic       en;
      logic       up;
      logic       load;
      logic [3:0] val;
      logic       tc;
      logic [3:0] cnt;
      logic [3:0] jk;
   } vec_t;

   typedef struct {
      int         idx;
      logic       sel;
      logic       tc;
      logic [3:0] cnt;
      logic [3:0] jk;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic       s_tc[2];
   logic [3:0] s_j[2];
   logic [3:0] s_k[2];

   task automatic check(input string name, input int idx, input logic [3:0] act,
                        input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s vec %0d: got %h want %h at %0t", name, idx, act, req, $time);
      end
   endtask

   task automatic add(input logic sel, input logic en, input logic up, input logic load,
                      input logic [3:0] val, input logic tc, input logic [3:0] cnt,
                      input logic [3:0] jk);
      vec_t v;
      v = '{sel: sel, en: en, up: up, load: load, val: val, tc: tc, cnt: cnt, jk: jk};
      vecs.push_back(v);
   endtask

   task automatic drive(input logic sel, input logic en, input logic up, input logic load,
                        input logic [3:0] val);
      bus10.en = 1'b0; bus10.load = 1'b0; bus10.up = 1'b1; bus10.load_val = '0;
      bus16.en = 1'b0; bus16.load = 1'b0; bus16.up = 1'b1; bus16.load_val = '0;
      if (!sel) begin
         bus10.en = en; bus10.up = up; bus10.load = load; bus10.load_val = val;
      end else begin
         bus16.en = en; bus16.up = up; bus16.load = load; bus16.load_val = val;
      end
   endtask

   task automatic run(input int from, input int to);
      exp_t e;
      for (int i = from; i < to; i++) begin
         @(negedge clk);
         drive(vecs[i].sel, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].val);
         e = '{idx: i, sel: vecs[i].sel, tc: vecs[i].tc, cnt: vecs[i].cnt, jk: vecs[i].jk};
         sb.push_back(e);
      end
      @(posedge clk);
      #2;
   endtask

   // Pre-edge samples of the combinational outputs, after the driver has settled.
   always @(negedge clk) begin
      #2;
      s_tc[0] = bus10.tc;  s_j[0] = dut10.w_j;  s_k[0] = dut10.w_k;
      s_tc[1] = bus16.tc;  s_j[1] = dut16.w_j;  s_k[1] = dut16.w_k;
   end

   initial begin : monitor
      exp_t       e;
      logic [3:0] cnt;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            cnt = e.sel ? bus16.count : bus10.count;
            check("tc", e.idx, {3'b000, s_tc[e.sel]}, {3'b000, e.tc});
            check("j", e.idx, s_j[e.sel], e.jk);
            check("k", e.idx, s_k[e.sel], e.jk);
            check("count", e.idx, cnt, e.cnt);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      // Part 1, MODULUS=10 from reset: holds, up wrap, down wrap, loads, clamps.
      add(0, 0, 1, 0, 4'd0,  0, 4'd0, 4'h0);
      add(0, 0, 0, 0, 4'd0,  0, 4'd0, 4'h0);
      add(0, 1, 1, 0, 4'd0,  0, 4'd1, 4'h1);
      add(0, 1, 1, 0, 4'd0,  0, 4'd2, 4'h3);
      add(0, 1, 1, 0, 4'd0,  0, 4'd3, 4'h1);
      add(0, 1, 1, 0, 4'd0,  0, 4'd4, 4'h7);
      add(0, 1, 1, 0, 4'd0,  0, 4'd5, 4'h1);
      add(0, 1, 1, 0, 4'd0,  0, 4'd6, 4'h3);
      add(0, 1, 1, 0, 4'd0,  0, 4'd7, 4'h1);
      add(0, 1, 1, 0, 4'd0,  0, 4'd8, 4'hF);
      add(0, 1, 1, 0, 4'd0,  0, 4'd9, 4'h1);
      add(0, 1, 1, 0, 4'd0,  1, 4'd0, 4'h9);
      add(0, 1, 1, 1, 4'd2,  0, 4'd2, 4'h2);
      add(0, 1, 0, 0, 4'd0,  0, 4'd1, 4'h3);
      add(0, 1, 0, 0, 4'd0,  0, 4'd0, 4'h1);
      add(0, 1, 0, 0, 4'd0,  1, 4'd9, 4'h9);
      add(0, 1, 0, 0, 4'd0,  0, 4'd8, 4'h1);
      add(0, 1, 1, 0, 4'd0,  0, 4'd9, 4'h1);
      add(0, 1, 1, 1, 4'd5,  0, 4'd5, 4'hC);
      add(0, 1, 1, 1, 4'd13, 0, 4'd9, 4'hC);
      add(0, 1, 0, 1, 4'd0,  0, 4'd0, 4'h9);
      add(0, 1, 0, 1, 4'd3,  0, 4'd3, 4'h3);
      add(0, 1, 1, 0, 4'd0,  0, 4'd4, 4'h7);
      add(0, 1, 0, 0, 4'd0,  0, 4'd3, 4'h7);
      add(0, 0, 1, 1, 4'd15, 0, 4'd9, 4'hA);
      add(0, 0, 1, 1, 4'd10, 0, 4'd9, 4'h0);
      add(0, 0, 0, 1, 4'd7,  0, 4'd7, 4'hE);
      add(0, 0, 1, 0, 4'd0,  0, 4'd7, 4'h0);
      // Part 2, after the mid-count reset: hold at 0, then MODULUS=16 wrap both ways.
      add(0, 0, 1, 0, 4'd0,  0, 4'd0, 4'h0);
      add(0, 0, 0, 0, 4'd0,  0, 4'd0, 4'h0);
      add(1, 0, 1, 1, 4'd14, 0, 4'd14, 4'hE);
      add(1, 1, 1, 0, 4'd0,  0, 4'd15, 4'h1);
      add(1, 1, 1, 0, 4'd0,  1, 4'd0, 4'hF);
      add(1, 1, 0, 0, 4'd0,  1, 4'd15, 4'hF);
      add(1, 1, 0, 0, 4'd0,  0, 4'd14, 4'h1);

      drive(0, 0, 1, 0, 4'd0);
      #3;
      check("reset_count", -1, bus10.count, 4'd0);
      check("reset_tc_up", -1, {3'b000, bus10.tc}, 4'd0);
      bus10.en = 1'b1;
      bus10.up = 1'b0;
      #1;
      check("reset_tc_down_en", -1, {3'b000, bus10.tc}, 4'd1);
      drive(0, 0, 1, 0, 4'd0);
      @(negedge clk);
      clr = 1'b1;

      run(0, 28);

      // Off-edge asynchronous clear at count 7.
      check("pre_reset_count", -1, bus10.count, 4'd7);
      clr = 1'b0;
      #1;
      check("async_clear", -1, bus10.count, 4'd0);
      @(negedge clk);
      drive(0, 1, 1, 1, 4'd5);
      @(posedge clk);
      #1;
      check("load_under_reset", -1, bus10.count, 4'd0);
      @(negedge clk);
      drive(0, 0, 1, 0, 4'd0);
      clr = 1'b1;

      run(28, vecs.size());

      for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Synchronous modulo-N up/down counter built from a bank of one-bit JK flip-flop cells, one per count bit. Per-bit excitation logic computes J/K from the current and next count, so the block is the stage that drives the JK flip-flops and consumes their Q outputs as state. It provides a cascadable terminal-count output and a parallel load. It is the next-level block above the single JK flip-flop in our sequential-logic set.

## Interface

- `WIDTH`, 4: count width in bits.
- `MODULUS`, 10: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH; anything else fails an elaboration check.

- `clk` in 1: single clock; all state changes on its rising edge.
- `clr` in 1: reset, asynchronous and active-low. It clears every JK cell.
- `en` in 1: count enable.
- `up` in 1: direction, 1 = increment, 0 = decrement.
- `load` in 1: synchronous parallel load.
- `load_val` in WIDTH: value to load.
- `count` out WIDTH: current count, taken directly from the JK cell Q outputs.
- `tc` out 1: terminal count / carry-out for cascading.

## Operation

- Reset: while `clr`=0, `count`=0 immediately, independent of `clk`. Releasing `clr` takes effect at the next rising edge.
- Next-state priority, evaluated each rising edge with `clr`=1:
  - `load`=1: next = `load_val` if `load_val` < MODULUS, else MODULUS-1 (clamped).
  - else `en`=1, `up`=1: next = 0 if count = MODULUS-1, else count+1.
  - else `en`=1, `up`=0: next = MODULUS-1 if count = 0, else count-1.
  - else: next = count (hold).
- JK excitation per bit i, toggle form: J_i = K_i = count_i XOR next_i.
  - Bits that change toggle; bits that do not change hold (J=K=0).
  - The set/reset encodings are never driven.
- Arithmetic: WIDTH-bit unsigned. The increment and decrement are computed one bit wider internally so the wrap compare never aliases. The block wraps at MODULUS, never at 2**WIDTH unless MODULUS = 2**WIDTH.
- Out-of-range state: if `count` ≥ MODULUS (only reachable through a faulty cell), the next increment goes to 0 and the next decrement goes to MODULUS-1.
- `tc`: combinational, defined as `en` AND NOT `load` AND (`up` ? count = MODULUS-1 : count = 0).
- `tc` must be asserted exactly in the cycle whose rising edge performs the wrap.

## Timing

- `count` changes only at a rising edge of `clk`, or asynchronously on `clr` falling.
- Load, step and wrap latency is one cycle: the value is visible after the edge at which the input was sampled.
- `tc` has zero latency from `count`/`en`/`up`/`load`; no registered stage.
- Reset values:
  - `count`=0.
  - `tc`=0 if `up`=1.
  - `tc`=`en` if `up`=0, because down-counting from 0 is terminal.
- Reset mid-count: state is lost immediately and `count`=0. A `load` sampled at the same edge that `clr` is released is ignored.
- Direction change mid-count takes effect on the next edge with no extra cycle.
- Simultaneous `load` and `en`: `load` wins and `tc`=0.

## Structure

- Shared package `jk_pkg`:
  - JK action encodings: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - A function returning the JK pair for (cur, next).
- Sub-module `jk_cell`:
  - One-bit JK flip-flop with asynchronous active-low `clr`.
  - Q'=Q for 00, 0 for 01, 1 for 10, ~Q for 11.
  - Instantiated WIDTH times with a generate loop.
- Top level holds only next-state, clamp, excitation and `tc` logic. No other state.

## Test plan

- Reset: drive `clr`=0 mid-count at count=7, off a clock edge. Require `count`=0 within the same timestep. Release `clr`, then with `en`=0 require hold at 0.
- Up wrap (WIDTH=4, MODULUS=10), `en`=1, `up`=1:
  - 10 edges from 0 give the sequence 1..9 then 0.
  - `tc`=1 only while count=9.
- Down wrap: load 2, then `up`=0 for 4 edges. Require 1, 0, 9, 8, with `tc`=1 only while count=0.
- Load: `load_val`=5 with `en`=1 gives 5 and `tc`=0 that cycle. `load_val`=13 gives 9 (clamped).
- Excitation check: going 7→8 with `up`=1, require J=K=1 on bits 0–3. Going 8→9, require J=K=1 on bit 0 only.
- MODULUS=16: require wrap at 15→0, and elaboration fails for MODULUS=17.
